// File: rtl/freq_meter_pkg.sv
// Shared types and defaults for the gated-window frequency meter.
package freq_meter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        GATE    = 2'd2,
        PUBLISH = 2'd3
    } state_e;

    localparam int unsigned GATE_CYCLES_DEF = 100_000_000;
    localparam int unsigned CNT_W_DEF       = 32;
    localparam logic [CNT_W_DEF-1:0] CNT_MAX = {CNT_W_DEF{1'b1}};

endpackage

// File: rtl/sig_sync_edge.sv
// Synchronizer chain for the measured signal plus a rising-edge detector whose
// history register is only advanced while armed or gating.
module sig_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic sig_i,
    input  logic load_prev_i,
    input  logic track_i,
    output logic rise_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s_prev_q;
    logic                   s;

    assign s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q   <= '0;
            s_prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sig_i};
            // Loading in ARM means a level already high at gate open is not an edge.
            if (load_prev_i || track_i) begin
                s_prev_q <= s;
            end
        end
    end

    assign rise_o = s & ~s_prev_q;

endmodule

// File: rtl/freq_gate_counter.sv
// Counts rising edges of sig_in over a fixed refclk gate window and holds the
// result for the consumer behind a valid/ack register.
module freq_gate_counter
    import freq_meter_pkg::*;
#(
    parameter int unsigned GATE_CYCLES = GATE_CYCLES_DEF,
    parameter int unsigned CNT_W       = CNT_W_DEF,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             refclk,
    input  logic             rst,
    input  logic             locked,
    input  logic             sig_in,
    input  logic             start,
    input  logic             cont,
    output logic [CNT_W-1:0] meas_count,
    output logic             meas_valid,
    input  logic             meas_ack,
    output logic             overflow,
    output logic             missed,
    output logic             busy
);

    localparam int unsigned      GW        = $clog2(GATE_CYCLES);
    localparam logic [GW-1:0]    GATE_LAST = GW'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_TOP   = {CNT_W{1'b1}};

    state_e            state_q;
    logic [GW-1:0]     gate_cnt_q;
    logic [CNT_W-1:0]  edge_cnt_q;
    logic              ovf_q;
    logic [CNT_W-1:0]  meas_count_q;
    logic              meas_valid_q;
    logic              overflow_q;
    logic              missed_q;
    logic              busy_q;
    logic              rise;

    sig_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk_i       (refclk),
        .rst_i       (rst),
        .sig_i       (sig_in),
        .load_prev_i (state_q == ARM),
        .track_i     (state_q == GATE),
        .rise_o      (rise)
    );

    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q      <= IDLE;
            gate_cnt_q   <= '0;
            edge_cnt_q   <= '0;
            ovf_q        <= 1'b0;
            meas_count_q <= '0;
            meas_valid_q <= 1'b0;
            overflow_q   <= 1'b0;
            missed_q     <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            if (meas_ack && meas_valid_q) begin
                meas_valid_q <= 1'b0;
                missed_q     <= 1'b0;
            end

            unique case (state_q)
                IDLE: begin
                    if (locked && (start || cont)) begin
                        state_q <= ARM;
                        busy_q  <= 1'b1;
                    end
                end
                ARM: begin
                    gate_cnt_q <= '0;
                    edge_cnt_q <= '0;
                    ovf_q      <= 1'b0;
                    if (!locked) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        state_q <= GATE;
                    end
                end
                GATE: begin
                    if (!locked) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        gate_cnt_q <= gate_cnt_q + 1'b1;
                        if (rise) begin
                            if (edge_cnt_q == CNT_TOP) begin
                                ovf_q <= 1'b1;
                            end else begin
                                edge_cnt_q <= edge_cnt_q + 1'b1;
                            end
                        end
                        if (gate_cnt_q == GATE_LAST) begin
                            state_q <= PUBLISH;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                PUBLISH: begin
                    // Overrides any same-cycle ack: the fresh result stays valid.
                    meas_count_q <= edge_cnt_q;
                    overflow_q   <= ovf_q;
                    meas_valid_q <= 1'b1;
                    missed_q     <= missed_q | meas_valid_q;
                    if (cont && locked) begin
                        state_q <= ARM;
                        busy_q  <= 1'b1;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign meas_count = meas_count_q;
    assign meas_valid = meas_valid_q;
    assign overflow   = overflow_q;
    assign missed     = missed_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_freq_gate_counter.sv
// Bench for freq_gate_counter: directed scenarios with literal expectations plus
// randomized traffic, all compared every cycle against a behavioural model.
module tb_freq_gate_counter;

    localparam int unsigned G    = 100;
    localparam int unsigned CW   = 4;
    localparam int          CMAX = (1 << CW) - 1;

    logic          refclk = 1'b0;
    logic          rst = 1'b1;
    logic          locked = 1'b1;
    logic          sig_in = 1'b0;
    logic          start = 1'b0;
    logic          cont = 1'b0;
    logic          meas_ack = 1'b0;
    logic [CW-1:0] meas_count;
    logic          meas_valid;
    logic          overflow;
    logic          missed;
    logic          busy;

    int n_checks = 0;
    int n_errors = 0;

    freq_gate_counter #(
        .GATE_CYCLES (G),
        .CNT_W       (CW),
        .SYNC_STAGES (2)
    ) dut (
        .refclk     (refclk),
        .rst        (rst),
        .locked     (locked),
        .sig_in     (sig_in),
        .start      (start),
        .cont       (cont),
        .meas_count (meas_count),
        .meas_valid (meas_valid),
        .meas_ack   (meas_ack),
        .overflow   (overflow),
        .missed     (missed),
        .busy       (busy)
    );

    always #5 refclk = ~refclk;

    // Signal generator: 0 = constant level, 1 = square wave, 2 = random bits.
    int gen_mode = 0;
    int gen_level = 0;
    int gen_period = 10;
    int gen_ph = 0;

    // Behavioural model: phases of one measurement, gate length counted down.
    localparam int PH_IDLE = 0, PH_ARM = 1, PH_GATE = 2, PH_PUB = 3;
    int   m_phase = PH_IDLE;
    int   m_left = 0;
    int   m_edges = 0;
    bit   m_sat = 0;
    int   m_count = 0;
    bit   m_valid = 0, m_ovf = 0, m_missed = 0, m_busy = 0;
    bit   started = 0;
    bit [2:0] hist = '0;   // sig_in samples at the last three edges, newest in bit 0

    always @(posedge refclk) begin
        bit rise_now, old_valid, old_missed;
        if (rst) begin
            m_phase = PH_IDLE; m_left = 0; m_edges = 0; m_sat = 0;
            m_count = 0; m_valid = 0; m_ovf = 0; m_missed = 0; m_busy = 0;
            hist = '0;
            started = 1;
        end else begin
            // Edge seen by the gate is the synchronized signal two samples back.
            rise_now   = hist[1] & ~hist[2];
            old_valid  = m_valid;
            old_missed = m_missed;
            if (meas_ack && m_valid) begin
                m_valid = 0; m_missed = 0;
            end
            case (m_phase)
                PH_IDLE: if (locked && (start || cont)) m_phase = PH_ARM;
                PH_ARM: begin
                    if (!locked) m_phase = PH_IDLE;
                    else begin
                        m_phase = PH_GATE; m_left = G; m_edges = 0; m_sat = 0;
                    end
                end
                PH_GATE: begin
                    if (!locked) m_phase = PH_IDLE;
                    else begin
                        if (rise_now) begin
                            if (m_edges == CMAX) m_sat = 1;
                            else m_edges++;
                        end
                        m_left--;
                        if (m_left == 0) m_phase = PH_PUB;
                    end
                end
                default: begin
                    m_count  = m_edges;
                    m_ovf    = m_sat;
                    m_valid  = 1;
                    m_missed = old_missed | old_valid;
                    m_phase  = (cont && locked) ? PH_ARM : PH_IDLE;
                end
            endcase
            m_busy = (m_phase == PH_ARM) || (m_phase == PH_GATE);
            hist = {hist[1:0], sig_in};
        end
    end

    always @(negedge refclk) begin
        logic [CW+3:0] act, exp;
        if (started) begin
            act = {meas_count, meas_valid, overflow, missed, busy};
            exp = {CW'(m_count), m_valid, m_ovf, m_missed, m_busy};
            n_checks++;
            if (act !== exp) begin
                n_errors++;
                $display("FAIL model_cmp t=%0t count/valid/ovf/missed/busy got %h expected %h",
                         $time, act, exp);
            end
        end
    end

    task automatic tick();
        @(posedge refclk);
        #1;
        case (gen_mode)
            0:       sig_in = gen_level[0];
            1:       sig_in = ((gen_ph % gen_period) < (gen_period / 2));
            default: sig_in = $urandom_range(0, 1);
        endcase
        gen_ph++;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic ack_pulse();
        meas_ack = 1'b1;
        tick();
        meas_ack = 1'b0;
    endtask

    // Pulse start and count clocks until meas_valid is seen (bounded).
    task automatic start_and_wait(output int lat);
        start = 1'b1;
        tick();
        start = 1'b0;
        lat = 0;
        while (!meas_valid && lat < 300) begin
            tick();
            lat++;
        end
    endtask

    initial begin
        int lat;
        repeat (3) tick();
        chk("reset_count", meas_count, 0);
        chk("reset_flags", {meas_valid, overflow, missed, busy}, 0);
        rst = 1'b0;
        gen_mode = 1; gen_period = 10;
        repeat (5) tick();

        // Steady 10-cycle period: 100-cycle window holds exactly 10 rising edges.
        start_and_wait(lat);
        chk("steady_latency", lat, 102);
        chk("steady_count", meas_count, 10);
        chk("steady_ovf_missed", {overflow, missed}, 0);

        // Continuous mode, two gates without ack.
        ack_pulse();
        chk("ack_clears_valid", meas_valid, 0);
        cont = 1'b1;
        lat = 0;
        while (!meas_valid && lat < 300) begin tick(); lat++; end
        cont = 1'b0;
        chk("cont_first_missed", missed, 0);
        repeat (102) tick();
        chk("cont_second_missed", missed, 1);
        chk("cont_idle_after", busy, 0);
        ack_pulse();
        chk("ack_clears_both", {meas_valid, missed}, 0);
        chk("ack_holds_count", meas_count, 10);

        // Lock loss half way through the gate.
        start = 1'b1; tick(); start = 1'b0;
        repeat (50) tick();
        chk("lock_busy_before", busy, 1);
        locked = 1'b0;
        tick();
        chk("lock_abort_busy", busy, 0);
        chk("lock_abort_valid", meas_valid, 0);
        repeat (4) tick();
        locked = 1'b1;
        repeat (2) tick();
        chk("lock_no_autorestart", busy, 0);
        start_and_wait(lat);
        chk("lock_resume_latency", lat, 102);
        chk("lock_resume_count", meas_count, 10);

        // Saturation with a 2-cycle period: 50 edges into a 4-bit counter.
        ack_pulse();
        gen_period = 2;
        start_and_wait(lat);
        chk("sat_count", meas_count, CMAX);
        chk("sat_ovf", overflow, 1);

        // Level high at gate open, ack coincident with PUBLISH; old result unacked.
        gen_mode = 0; gen_level = 1;
        repeat (5) tick();
        start = 1'b1; tick(); start = 1'b0;
        repeat (101) tick();
        meas_ack = 1'b1; tick(); meas_ack = 1'b0;
        chk("level_valid_kept", meas_valid, 1);
        chk("level_count", meas_count, 0);
        chk("level_ovf", overflow, 0);
        chk("level_missed", missed, 1);

        // Reset in the middle of a gate.
        gen_mode = 1; gen_period = 10;
        start = 1'b1; tick(); start = 1'b0;
        repeat (30) tick();
        rst = 1'b1; tick(); rst = 1'b0;
        chk("rst_mid_count", meas_count, 0);
        chk("rst_mid_flags", {meas_valid, overflow, missed, busy}, 0);
        repeat (3) tick();
        start_and_wait(lat);
        chk("rst_after_latency", lat, 102);
        chk("rst_after_count", meas_count, 10);

        // Randomized traffic; correctness carried by the per-cycle model compare.
        for (int i = 0; i < 4000; i++) begin
            if (i % 400 == 0) begin
                gen_mode   = $urandom_range(0, 2);
                gen_level  = $urandom_range(0, 1);
                gen_period = $urandom_range(2, 14);
            end
            start    = ($urandom_range(0, 29) == 0);
            meas_ack = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 299) == 0) cont = ~cont;
            locked   = ($urandom_range(0, 249) != 0);
            rst      = ($urandom_range(0, 1499) == 0);
            tick();
        end
        start = 1'b0; meas_ack = 1'b0; cont = 1'b0; locked = 1'b1; rst = 1'b0;
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
